mdu_div_seq: RTL
================

MDU_DIV_SEQ -- requirements
Module: mdu_div_seq

Interface
REQ-001 The block SHALL have no parameters; the operand width SHALL be fixed at 32 bits.
REQ-002 The port clk SHALL be an input, 1 bit wide, and be the single clock; all state SHALL update on its rising edge.
REQ-003 The port rst_n SHALL be an input, 1 bit wide; reset SHALL be synchronous and active-low.
REQ-004 The port start SHALL be an input, 1 bit wide, and request a divide operation from the execute stage.
REQ-005 The port funct3 SHALL be an input, 3 bits wide, with encodings 100 DIV, 101 DIVU, 110 REM and 111 REMU.
REQ-006 The ports op1 and op2 SHALL be inputs, 32 bits each, carrying the dividend and divisor.
REQ-007 The port flush SHALL be an input, 1 bit wide, and abort any in-flight operation.
REQ-008 The port stall SHALL be an output, 1 bit wide, and hold the pipeline while a divide is in progress.
REQ-009 The port busy SHALL be an output, 1 bit wide, and be high in any state other than IDLE.
REQ-010 The port done SHALL be an output, 1 bit wide, and be a one-cycle pulse marking result valid.
REQ-011 The port result SHALL be an output, 32 bits wide, carrying the quotient or remainder selected by funct3.

Function
REQ-012 The FSM SHALL have the states IDLE, PREP, CALC, FIX and DONE.
REQ-013 Start SHALL be accepted only in IDLE with funct3[2]=1 and flush=0; start with funct3[2]=0 SHALL be ignored, leaving the FSM in IDLE.
REQ-014 On acceptance the block SHALL latch op1, op2 and funct3 internally; later input changes SHALL have no effect on the operation.
REQ-015 Special case, op2==0: the FSM SHALL go IDLE->DONE with quotient 0xFFFFFFFF and remainder = op1, for signed and unsigned alike.
REQ-016 Special case, signed overflow (DIV/REM, op1==0x80000000, op2==0xFFFFFFFF): the FSM SHALL go IDLE->DONE with quotient 0x80000000 and remainder 0.
REQ-017 Normal path SHALL be IDLE->PREP (1 cycle) ->CALC (exactly 32 cycles, counted by a 5-bit counter that wraps 31->0 to exit) ->FIX (1 cycle) ->DONE (1 cycle) ->IDLE.
REQ-018 In PREP, signed ops SHALL take absolute values of both operands and record quotient sign = op1[31]^op2[31] and remainder sign = op1[31].
REQ-019 In CALC, each cycle SHALL perform one radix-2 restoring step on a 33-bit partial remainder, producing one quotient bit MSB-first.
REQ-020 In FIX, the quotient and remainder SHALL be negated when their recorded sign is set; the remainder sign SHALL always equal the dividend sign.
REQ-021 Latency: with start sampled at edge 0, done SHALL be high in cycle 35 on the normal path and in cycle 1 on the special paths.
REQ-022 done SHALL be high only in DONE, for exactly one cycle; result SHALL update on entry to DONE and hold until the next completion.
REQ-023 stall SHALL equal (IDLE & accepted start) | PREP | CALC | FIX; it SHALL be low in DONE so the pipeline advances and consumes result.
REQ-024 start in any non-IDLE state, including DONE, SHALL be ignored; DONE SHALL always return to IDLE.
REQ-025 Flush in any state SHALL force IDLE on the next edge, suppress done for the aborted op and leave result unchanged.
REQ-026 Flush and start in the same IDLE cycle SHALL mean no acceptance, and stall SHALL be low.

Reset
REQ-027 rst_n=0 sampled on an edge SHALL force IDLE, counter 0, busy=0, done=0, stall=0 (with start low) and result=0x00000000.
REQ-028 Reset mid-operation SHALL abort without a done pulse; reset SHALL take priority over flush and start.

Verification
REQ-029 DIVU 100/7 -> stall high for cycles 0-34, done in cycle 35, result 0x0000000E; REMU with the same operands -> 0x00000002.
REQ-030 DIV -7/2 -> result 0xFFFFFFFD (-3); REM -7/2 -> 0xFFFFFFFF (-1); DIV 7/-2 -> 0xFFFFFFFD.
REQ-031 DIV 5/0 -> done in cycle 1 with result 0xFFFFFFFF; REMU 5/0 -> 0x00000005.
REQ-032 DIV 0x80000000/0xFFFFFFFF -> done in cycle 1 with result 0x80000000; REM with the same operands -> 0x00000000.
REQ-033 Flush asserted in CALC cycle 10 -> IDLE next cycle, no done pulse, result keeps its prior value; a new start afterwards completes correctly.
REQ-034 Reset asserted in CALC, and start pulsed while busy or with funct3=000 -> no extra done pulse and no state corruption.

Source files
------------

// File: rtl/mdu_div_seq.sv
// Sequential 32-bit divider for the RV32M DIV/DIVU/REM/REMU instructions.
// Uses radix-2 restoring division, one quotient bit per cycle, with early exits for divide-by-zero and signed overflow.
module mdu_div_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  funct3,
    input  logic [31:0] op1,
    input  logic [31:0] op2,
    input  logic        flush,
    output logic        stall,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    state_t      r_state;
    logic [4:0]  r_cnt;
    logic        r_busy;
    logic        r_done;
    logic [31:0] r_result;
    logic [31:0] r_op1;
    logic [31:0] r_op2;
    logic [1:0]  r_fn;
    logic [31:0] r_quo;
    logic [31:0] r_dvsr;
    logic [31:0] r_rem;
    logic        r_qneg;
    logic        r_rneg;

    logic        w_accept;
    logic        w_signed_in;
    logic        w_div0;
    logic        w_ovf;
    logic [32:0] w_shift;
    logic [32:0] w_diff;
    logic        w_qbit;
    logic [31:0] w_quo_fix;
    logic [31:0] w_rem_fix;

    function automatic logic [31:0] f_cneg(input logic [31:0] val, input logic neg);
        return neg ? (~val + 32'd1) : val;
    endfunction

    // 0x80000000 maps to itself, which is still correct when read as an unsigned magnitude.
    function automatic logic [31:0] f_abs(input logic [31:0] val, input logic is_signed);
        return f_cneg(val, is_signed & val[31]);
    endfunction

    assign w_accept    = (r_state == S_IDLE) & start & funct3[2] & ~flush;
    assign w_signed_in = ~funct3[0];
    assign w_div0      = (op2 == 32'd0);
    assign w_ovf       = w_signed_in & (op1 == 32'h8000_0000) & (op2 == 32'hFFFF_FFFF);

    // The partial remainder is always below the divisor, so it fits in 32 bits between steps.
    // Only the shifted trial value needs 33 bits, and its MSB then acts as the borrow.
    assign w_shift   = {r_rem, r_quo[31]};
    assign w_diff    = w_shift - {1'b0, r_dvsr};
    assign w_qbit    = ~w_diff[32];
    assign w_quo_fix = f_cneg(r_quo, r_qneg);
    assign w_rem_fix = f_cneg(r_rem, r_rneg);

    assign stall  = w_accept | (r_state == S_PREP) | (r_state == S_CALC) | (r_state == S_FIX);
    assign busy   = r_busy;
    assign done   = r_done;
    assign result = r_result;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= 5'd0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= 32'd0;
        end else if (flush) begin
            r_state <= S_IDLE;
            r_cnt   <= 5'd0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op1  <= op1;
                        r_op2  <= op2;
                        r_fn   <= funct3[1:0];
                        r_busy <= 1'b1;
                        if (w_div0) begin
                            r_result <= funct3[1] ? op1 : 32'hFFFF_FFFF;
                            r_done   <= 1'b1;
                            r_state  <= S_DONE;
                        end else if (w_ovf) begin
                            r_result <= funct3[1] ? 32'd0 : 32'h8000_0000;
                            r_done   <= 1'b1;
                            r_state  <= S_DONE;
                        end else begin
                            r_state <= S_PREP;
                        end
                    end
                end
                S_PREP: begin
                    r_quo   <= f_abs(r_op1, ~r_fn[0]);
                    r_dvsr  <= f_abs(r_op2, ~r_fn[0]);
                    r_rem   <= 32'd0;
                    r_qneg  <= ~r_fn[0] & (r_op1[31] ^ r_op2[31]);
                    r_rneg  <= ~r_fn[0] & r_op1[31];
                    r_cnt   <= 5'd0;
                    r_state <= S_CALC;
                end
                S_CALC: begin
                    r_rem   <= w_qbit ? w_diff[31:0] : w_shift[31:0];
                    r_quo   <= {r_quo[30:0], w_qbit};
                    r_cnt   <= r_cnt + 5'd1;
                    if (r_cnt == 5'd31) begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    r_result <= r_fn[1] ? w_rem_fix : w_quo_fix;
                    r_done   <= 1'b1;
                    r_state  <= S_DONE;
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
